// File: rtl/lfsr_pkg.sv
// Shared definitions for the lfsr_gen sequence generator.
// Mode encodings and the burst controller state type.
package lfsr_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'd0;
  localparam logic [1:0] MODE_RUN   = 2'd1;
  localparam logic [1:0] MODE_STEP  = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic {
    BS_IDLE,
    BS_RUN
  } burst_t;

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step: shift left, XOR of tapped bits
// enters at bit 0.
module lfsr_step #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic fb;

  assign fb   = ^(din & TAPS);
  assign dout = {din[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_gen.sv
// Seedable LFSR with leap stepping, run/step/burst modes and
// wrap/period characterisation outputs.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 1,
  parameter int               LEAP         = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_we,
  input  logic [WIDTH-1:0] seed,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic [7:0]       burst_len,
  output logic [WIDTH-1:0] lfsr_bits,
  output logic             serial_out,
  output logic             out_valid,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             busy,
  output logic             zero_seed
);

  logic [LEAP:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]         nxt;
  logic [WIDTH-1:0]         ld;
  logic [WIDTH-1:0]         start;
  logic [WIDTH-1:0]         cnt;
  logic [7:0]               rem_q;
  logic [7:0]               rem_nxt;
  burst_t                   burst_q;
  burst_t                   burst_nxt;
  logic                     adv;

  assign chain[0] = lfsr_bits;

  for (genvar g = 0; g < LEAP; g++) begin : g_leap
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .din  (chain[g]),
      .dout (chain[g+1])
    );
  end

  assign nxt        = chain[LEAP];
  assign ld         = (seed == '0) ? DEFAULT_SEED : seed;
  assign serial_out = lfsr_bits[WIDTH-1];
  assign busy       = (burst_q == BS_RUN);

  always_comb begin
    adv       = 1'b0;
    burst_nxt = burst_q;
    rem_nxt   = rem_q;
    unique case (1'b1)
      mode == MODE_RUN:  adv = 1'b1;
      mode == MODE_STEP: adv = step;
      mode == MODE_BURST: begin
        if (burst_q == BS_IDLE) begin
          if (step && burst_len != 8'd0) begin
            burst_nxt = BS_RUN;
            rem_nxt   = burst_len;
          end
        end else begin
          adv     = 1'b1;
          rem_nxt = rem_q - 8'd1;
          if (rem_q == 8'd1)
            burst_nxt = BS_IDLE;
        end
      end
      default: ;
    endcase
    // Leaving BURST abandons any burst without a final advance.
    if (mode != MODE_BURST) begin
      burst_nxt = BS_IDLE;
      rem_nxt   = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_bits <= DEFAULT_SEED;
      start     <= DEFAULT_SEED;
      cnt       <= '0;
      period    <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      zero_seed <= 1'b0;
      burst_q   <= BS_IDLE;
      rem_q     <= 8'd0;
    end else if (seed_we) begin
      lfsr_bits <= ld;
      start     <= ld;
      cnt       <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      zero_seed <= (seed == '0);
      burst_q   <= BS_IDLE;
      rem_q     <= 8'd0;
    end else begin
      out_valid <= adv;
      wrap      <= 1'b0;
      zero_seed <= 1'b0;
      burst_q   <= burst_nxt;
      rem_q     <= rem_nxt;
      if (adv) begin
        lfsr_bits <= nxt;
        if (nxt == start) begin
          wrap   <= 1'b1;
          period <= cnt + 1'b1;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: single-step and leap-4 instances
// share stimulus; expected values are hand-derived.
module tb_lfsr_gen;
  import lfsr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_we;
  logic [7:0] seed;
  logic [1:0] mode;
  logic       step;
  logic [7:0] burst_len;

  logic [7:0] a_bits, a_period;
  logic       a_ser, a_valid, a_wrap, a_busy, a_zero;
  logic [7:0] b_bits, b_period;
  logic       b_ser, b_valid, b_wrap, b_busy, b_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lfsr_gen #(
    .WIDTH(8), .TAPS(8'hB8), .DEFAULT_SEED(8'h01), .LEAP(1)
  ) dut_a (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed(seed),
    .mode(mode), .step(step), .burst_len(burst_len),
    .lfsr_bits(a_bits), .serial_out(a_ser), .out_valid(a_valid),
    .wrap(a_wrap), .period(a_period), .busy(a_busy),
    .zero_seed(a_zero)
  );

  lfsr_gen #(
    .WIDTH(8), .TAPS(8'hB8), .DEFAULT_SEED(8'h01), .LEAP(4)
  ) dut_b (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed(seed),
    .mode(mode), .step(step), .burst_len(burst_len),
    .lfsr_bits(b_bits), .serial_out(b_ser), .out_valid(b_valid),
    .wrap(b_wrap), .period(b_period), .busy(b_busy),
    .zero_seed(b_zero)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    seed    = v;
    seed_we = 1'b1;
    tick;
    seed_we = 1'b0;
  endtask

  logic [7:0] seq_a [1:7];
  int         n;
  int         nb;
  int         wa;
  int         wb;

  initial begin
    seq_a[1] = 8'h02; seq_a[2] = 8'h04; seq_a[3] = 8'h08;
    seq_a[4] = 8'h11; seq_a[5] = 8'h23; seq_a[6] = 8'h47;
    seq_a[7] = 8'h8E;

    rst = 1'b1; seed_we = 1'b0; seed = 8'h00;
    mode = MODE_HOLD; step = 1'b0; burst_len = 8'd0;
    tick; tick;
    chk("rst_bits", a_bits, 8'h01);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_period", a_period, 8'h00);
    chk("rst_zero", a_zero, 1'b0);

    // Free run: single-step sequence and leap-4 chain together
    rst  = 1'b0;
    mode = MODE_RUN;
    wa = 0; wb = 0;
    for (int i = 1; i <= 7; i++) begin
      tick;
      chk("run_seq", a_bits, seq_a[i]);
      chk("run_valid", a_valid, 1'b1);
      if (i == 1) chk("leap_1", b_bits, 8'h11);
      if (i == 2) chk("leap_2", b_bits, 8'h1C);
      wa += int'(a_wrap);
      wb += int'(b_wrap);
    end
    chk("serial_hi", a_ser, 1'b1);
    for (int i = 8; i <= 255; i++) begin
      tick;
      wa += int'(a_wrap);
      wb += int'(b_wrap);
    end
    chk("wrap_bits", a_bits, 8'h01);
    chk("wrap_pulse", a_wrap, 1'b1);
    chk("wrap_count", wa, 1);
    chk("period", a_period, 8'd255);
    chk("leap_bits", b_bits, 8'h01);
    chk("leap_wraps", wb, 1);
    chk("leap_period", b_period, 8'd255);

    // Seed loading and zero substitution
    mode = MODE_HOLD;
    load(8'h00);
    chk("zs_bits", a_bits, 8'h01);
    chk("zs_pulse", a_zero, 1'b1);
    chk("zs_valid", a_valid, 1'b0);
    tick;
    chk("zs_clear", a_zero, 1'b0);
    load(8'h5A);
    chk("ld_bits", a_bits, 8'h5A);
    chk("ld_zero", a_zero, 1'b0);

    // Single stepping, then hold ignores step
    mode = MODE_STEP;
    load(8'h01);
    for (int i = 1; i <= 3; i++) begin
      step = 1'b1;
      tick;
      step = 1'b0;
      chk("step_bits", a_bits, seq_a[i]);
      chk("step_valid", a_valid, 1'b1);
      tick;
      chk("step_idle", a_valid, 1'b0);
    end
    mode = MODE_HOLD;
    step = 1'b1;
    tick; tick;
    step = 1'b0;
    chk("hold_bits", a_bits, 8'h08);
    chk("hold_valid", a_valid, 1'b0);

    // Burst of 4, with a step during busy ignored
    mode = MODE_BURST;
    load(8'h01);
    burst_len = 8'd4;
    step = 1'b1;
    tick;
    step = 1'b0;
    chk("bst_busy0", a_busy, 1'b1);
    chk("bst_lat", a_valid, 1'b0);
    n = 0; nb = 0;
    for (int k = 0; k < 8; k++) begin
      nb += int'(a_busy);
      n  += int'(a_valid);
      step = (k == 1);
      tick;
    end
    step = 1'b0;
    chk("bst_busy_n", nb, 4);
    chk("bst_valid_n", n, 4);
    chk("bst_bits", a_bits, 8'h11);
    chk("bst_done", a_busy, 1'b0);

    burst_len = 8'd0;
    step = 1'b1;
    tick;
    step = 1'b0;
    tick;
    chk("bst0_busy", a_busy, 1'b0);
    chk("bst0_valid", a_valid, 1'b0);
    chk("bst0_bits", a_bits, 8'h11);

    // Long burst aborted by a load at the tenth advance
    load(8'h01);
    burst_len = 8'd200;
    step = 1'b1;
    tick;
    step = 1'b0;
    n = 0;
    for (int g = 0; g < 50 && n < 10; g++) begin
      tick;
      n += int'(a_valid);
    end
    chk("abort_adv", n, 10);
    load(8'h33);
    chk("abort_busy", a_busy, 1'b0);
    chk("abort_bits", a_bits, 8'h33);
    chk("abort_valid", a_valid, 1'b0);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      n += int'(a_valid);
    end
    chk("abort_quiet", n, 0);
    chk("abort_hold", a_bits, 8'h33);

    // Reset in the middle of free run
    mode = MODE_RUN;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mode = MODE_HOLD;
    chk("mrst_bits", a_bits, 8'h01);
    chk("mrst_valid", a_valid, 1'b0);
    chk("mrst_wrap", a_wrap, 1'b0);
    chk("mrst_period", a_period, 8'h00);
    chk("mrst_leap", b_bits, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
